// File: rtl/stage_3_ex_pkg.sv
// ---------------------------------------------------------------------------
// stage_3_ex_pkg
//   Shared definitions for the execute stage:
//     - bus widths of the decode->execute and execute->memory bundles
//     - field offsets of both bundles plus matching packed struct views
//     - one-hot alu_op bit indices
// ---------------------------------------------------------------------------
package stage_3_ex_pkg;

    localparam int BUS_2_3_WIDTH = 117;
    localparam int BUS_3_4_WIDTH = 71;

    // decode -> execute bundle field offsets
    localparam int B23_PC_LSB       = 0;
    localparam int B23_MEM_EN       = 32;
    localparam int B23_MEM_WE       = 33;
    localparam int B23_ALU_OP_LSB   = 34;
    localparam int B23_SRC2_LSB     = 46;
    localparam int B23_SRC1_LSB     = 78;
    localparam int B23_RES_FROM_MEM = 110;
    localparam int B23_DEST_LSB     = 111;
    localparam int B23_RF_WE        = 116;

    // execute -> memory bundle field offsets
    localparam int B34_PC_LSB       = 0;
    localparam int B34_RESULT_LSB   = 32;
    localparam int B34_DEST_LSB     = 64;
    localparam int B34_RF_WE        = 69;
    localparam int B34_RES_FROM_MEM = 70;

    // one-hot alu_op bit indices
    localparam int ALU_OP_W = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Field order mirrors the offsets above (MSB first).
    typedef struct packed {
        logic                rf_we;
        logic [4:0]          dest;
        logic                res_from_mem;
        logic [31:0]         alu_src1;
        logic [31:0]         alu_src2;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_we;
        logic                mem_en;
        logic [31:0]         pc;
    } bus_2_3_t;

    typedef struct packed {
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } bus_3_4_t;

endpackage

// File: rtl/stage_3_ex_alu.sv
// ---------------------------------------------------------------------------
// stage_3_ex_alu
//   Purely combinational 32-bit ALU driven by a one-hot operation select.
//   Ports:
//     src1, src2  in  32  operands (shift amount is src2[4:0])
//     alu_op      in  12  one-hot operation select
//     alu_result  out 32  result; 0 when alu_op is all-zero
// ---------------------------------------------------------------------------
module stage_3_ex_alu
    import stage_3_ex_pkg::*;
(
    input  logic [31:0]         src1,
    input  logic [31:0]         src2,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_result
);

    logic [31:0] op_res    [ALU_OP_W];
    logic [31:0] op_masked [ALU_OP_W];
    logic [4:0]  shamt;

    assign shamt = src2[4:0];

    always_comb begin
        op_res[ALU_ADD]  = src1 + src2;
        op_res[ALU_SUB]  = src1 - src2;
        op_res[ALU_SLT]  = {31'd0, $signed(src1) < $signed(src2)};
        op_res[ALU_SLTU] = {31'd0, src1 < src2};
        op_res[ALU_AND]  = src1 & src2;
        op_res[ALU_NOR]  = ~(src1 | src2);
        op_res[ALU_OR]   = src1 | src2;
        op_res[ALU_XOR]  = src1 ^ src2;
        op_res[ALU_SLL]  = src1 << shamt;
        op_res[ALU_SRL]  = src1 >> shamt;
        op_res[ALU_SRA]  = $unsigned($signed(src1) >>> shamt);
        op_res[ALU_LUI]  = src2;
    end

    // AND-OR mux: each op's result is gated by its select bit, so an
    // all-zero alu_op naturally yields 0.
    genvar gi;
    generate
        for (gi = 0; gi < ALU_OP_W; gi++) begin : g_mask
            assign op_masked[gi] = op_res[gi] & {32{alu_op[gi]}};
        end
    endgenerate

    always_comb begin
        alu_result = 32'd0;
        for (int i = 0; i < ALU_OP_W; i++) begin
            alu_result = alu_result | op_masked[i];
        end
    end

endmodule

// File: rtl/stage_3_ex.sv
// ---------------------------------------------------------------------------
// stage_3_ex
//   Execute stage of the 5-stage in-order pipeline. Latches the decode
//   bundle and store data, runs the ALU, issues the data SRAM request and
//   forwards the result bundle to the memory stage.
//   Ports:
//     clk, reset          clock; synchronous active-high reset
//     valid_2, allow_3    decode handshake (allow_3 is our ready)
//     stage_2_to_3        117-bit decode bundle
//     memory_write_data   store data, captured with the bundle
//     valid_3, allow_4    memory-stage handshake
//     stage_3_to_4        71-bit bundle to the memory stage
//     rf_waddr_3_fwd      write-address interlock back to decode
//     data_sram_*         single-cycle data SRAM request
// ---------------------------------------------------------------------------
module stage_3_ex
    import stage_3_ex_pkg::*;
#(
    parameter int BUS_2_3_W = BUS_2_3_WIDTH,
    parameter int BUS_3_4_W = BUS_3_4_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_2,
    output logic                 allow_3,
    input  logic [BUS_2_3_W-1:0] stage_2_to_3,
    input  logic [31:0]          memory_write_data,
    output logic                 valid_3,
    input  logic                 allow_4,
    output logic [BUS_3_4_W-1:0] stage_3_to_4,
    output logic [4:0]           rf_waddr_3_fwd,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_we,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata
);

    // Single-cycle ALU: the stage never stalls on its own.
    localparam logic READYGO_3 = 1'b1;

    logic        valid_reg;
    bus_2_3_t    bundle_reg;
    logic [31:0] store_data_reg;
    logic        in_fire;
    logic [31:0] alu_result;
    bus_3_4_t    out_bus;

    assign allow_3 = ~valid_reg | (READYGO_3 & allow_4);
    assign in_fire = valid_2 & allow_3;
    assign valid_3 = valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
        end else if (allow_3) begin
            valid_reg <= valid_2;
        end
    end

    // Payload only moves on in_fire, so it stays stable through a stall.
    // When in_fire and out_fire coincide the new bundle overwrites the
    // departing one at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bundle_reg     <= '0;
            store_data_reg <= 32'd0;
        end else if (in_fire) begin
            bundle_reg     <= bus_2_3_t'(stage_2_to_3);
            store_data_reg <= memory_write_data;
        end
    end

    stage_3_ex_alu u_alu (
        .src1       (bundle_reg.alu_src1),
        .src2       (bundle_reg.alu_src2),
        .alu_op     (bundle_reg.alu_op),
        .alu_result (alu_result)
    );

    always_comb begin
        out_bus              = '0;
        out_bus.res_from_mem = bundle_reg.res_from_mem;
        out_bus.rf_we        = bundle_reg.rf_we;
        out_bus.dest         = bundle_reg.dest;
        out_bus.alu_result   = alu_result;
        out_bus.pc           = bundle_reg.pc;
    end

    assign stage_3_to_4 = out_bus;

    // Gating with ~reset keeps the interlock and the SRAM request quiet
    // during the reset cycle itself, not just after the reset edge.
    assign rf_waddr_3_fwd = (valid_reg & bundle_reg.rf_we & ~reset) ? bundle_reg.dest : 5'd0;

    // The enable is qualified by allow_4 so a stalled store is issued
    // exactly once, in the cycle the memory stage accepts it.
    assign data_sram_en    = valid_reg & bundle_reg.mem_en & allow_4 & ~reset;
    assign data_sram_we    = {4{data_sram_en & bundle_reg.mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = store_data_reg;

endmodule
